instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning word-address width; DEPTH <= 2**ADDR_W.
REQ-003 SHALL have port clock, input, 1, meaning sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the source presents a byte.
REQ-006 SHALL have port in_data, input, 8, meaning the stream byte.
REQ-007 SHALL have port in_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 SHALL have port imem_we, output, 1, meaning instruction-memory write strobe.
REQ-009 SHALL have port imem_addr, output, ADDR_W, meaning word index written.
REQ-010 SHALL have port imem_wdata, output, 32, meaning instruction word written.
REQ-011 SHALL have port core_reset, output, 1, meaning hold the datapath in reset until load completes.
REQ-012 SHALL have port done, output, 1, meaning load completed successfully.
REQ-013 SHALL have port err, output, 1, meaning load aborted.

Function
REQ-014 SHALL define a byte transfer as in_valid && in_ready on a rising edge; in_data is ignored otherwise.
REQ-015 SHALL use states LEN0, LEN1, DATA, CSUM, DONE, ERR, and enter LEN0 on reset.
REQ-016 SHALL, in LEN0, capture the transferred byte as word-count bits [7:0] and move to LEN1.
REQ-017 SHALL, in LEN1, capture the transferred byte as word-count bits [15:8], then:
- count == 0: go to CSUM if LOADER_CHECKSUM_EN is defined, else DONE.
- count > DEPTH: go to ERR.
- otherwise: go to DATA.
REQ-018 SHALL, in DATA, assemble bytes little-endian (first byte = bits [7:0]) using a 2-bit byte counter.
REQ-019 SHALL, on the transfer completing a word, pulse imem_we for exactly the next cycle, with imem_addr = word index (starting at 0) and imem_wdata = the assembled word.
REQ-020 SHALL increment the word index after each write, and leave DATA after the word index reaches count-1 is written, going to CSUM or DONE per REQ-017.
REQ-021 SHALL drive in_ready high only in LEN0, LEN1, DATA and CSUM.
REQ-022 SHALL hold in_ready low during the cycle that imem_we is high, so that one write per word never overlaps the next byte.
REQ-023 SHALL treat a deasserted in_valid as a stall: state, counters and the partial word are held indefinitely.
REQ-024 SHALL set done=1 and core_reset=0 in DONE.
REQ-025 SHALL set err=1 and keep core_reset=1 in ERR.
REQ-026 SHALL treat DONE and ERR as terminal; only reset exits them.
REQ-027 SHALL keep imem_we=0 in every state except the write cycle of REQ-019.

Reset
REQ-028 SHALL reset outputs to in_ready=0 (for the reset cycle), imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, err=0.
REQ-029 SHALL reset the word count, word index, byte counter and checksum to 0.
REQ-030 SHALL, on reset asserted mid-load, abandon the load without undoing words already written; the next stream restarts at LEN0.

Configuration
REQ-031 SHALL compile in checksum checking when macro LOADER_CHECKSUM_EN is defined:
- The checksum is the XOR of all DATA bytes.
- In CSUM, one byte is accepted; equal to the checksum goes to DONE, otherwise to ERR.
REQ-032 SHALL, without LOADER_CHECKSUM_EN, omit the CSUM state and checksum register, going from the last DATA write (or count == 0) directly to DONE.

Verification
REQ-033 SHALL cover the basic load:
- Stimulus: stream 02 00 13 00 00 00 B3 00 50 00.
- Response: writes addr0 = 0x00000013 and addr1 = 0x005000B3, then done=1, core_reset=0.
- With LOADER_CHECKSUM_EN: additionally send byte 0xF0, then done=1.
REQ-034 SHALL cover the overlong count: with DEPTH=64, stream 41 00 -> err=1, in_ready=0, core_reset=1, no imem_we.
REQ-035 SHALL cover the zero count: stream 00 00 (plus 00 if LOADER_CHECKSUM_EN) -> done=1 with no imem_we.
REQ-036 SHALL cover source gaps: stream of REQ-033 with in_valid low for 3 cycles between every byte -> identical writes and final state.
REQ-037 SHALL cover a bad checksum (LOADER_CHECKSUM_EN defined): stream of REQ-033 with checksum byte 0x00 -> both words written, then err=1, done=0.
REQ-038 SHALL cover reset mid-load: assert reset after 5 bytes of the REQ-033 stream -> outputs at reset values; a full REQ-033 stream afterwards -> done=1.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: receives a byte stream (16-bit little-endian word count followed
// by the instruction words, each sent least-significant byte first) and writes
// the words into instruction memory. The datapath is held in reset until the
// whole image is loaded.
//
// Optional checksum: define LOADER_CHECKSUM_EN to append one byte after the
// data. That byte must equal the XOR of all data bytes, or the load aborts.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   LEN0  | waiting for word-count low byte
//   LEN1  | waiting for word-count high byte, then range check
//   DATA  | assembling words; one imem write per completed word
//   CSUM  | waiting for checksum byte (LOADER_CHECKSUM_EN only)
//   DONE  | load complete, core released (terminal)
//   ERR   | load aborted, core kept in reset (terminal)
module instr_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_LEN0 = 3'd0;
  localparam logic [2:0] S_LEN1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd3;
  // Where the stream goes once all data words (possibly none) are written.
  localparam logic [2:0] S_END  = S_CSUM;
`else
  localparam logic [2:0] S_END  = S_DONE;
`endif

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  logic [2:0]        state;
  logic [15:0]       count;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       partial;
  logic              xfer;
  logic              accepting;
  logic [15:0]       len_full;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // Byte acceptance: only in input-taking states, never in the write cycle
  // and never while reset is asserted.
  always_comb begin
    accepting = 1'b0;
    case (state)
      S_LEN0, S_LEN1, S_DATA: accepting = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                 accepting = 1'b1;
`endif
      default:                accepting = 1'b0;
    endcase
    in_ready  = accepting && !imem_we && !reset;
    xfer      = in_valid && in_ready;
    len_full  = {in_data, count[7:0]};
    last_word = (16'(word_idx) == (count - 16'd1));
  end

  // Status outputs follow the state register directly.
  always_comb begin
    done       = (state == S_DONE);
    err        = (state == S_ERR);
    core_reset = (state != S_DONE);
  end

  // Load sequencer: length capture, word assembly, memory writes, checksum.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_LEN0;
      count      <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      partial    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN0: begin
          if (xfer) begin
            count[7:0] <= in_data;
            state      <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            count[15:8] <= in_data;
            if (len_full == 16'd0)       state <= S_END;
            else if (len_full > DEPTH_W) state <= S_ERR;
            else                         state <= S_DATA;
          end
        end
        S_DATA: begin
          // The write cycle decides whether this was the final word; the
          // index only advances when more words follow.
          if (imem_we) begin
            if (last_word) state    <= S_END;
            else           word_idx <= word_idx + 1'b1;
          end else if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= {in_data, partial};
            end else begin
              partial <= {in_data, partial[23:8]};
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) state <= (in_data == csum) ? S_DONE : S_ERR;
        end
`endif
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: table of directed streams, randomized streams checked
// against a word-level reference model, and a reset-during-load sequence.
module tb_instr_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              err;

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  typedef struct packed {
    logic [0:11][7:0] bytes;
    logic [3:0]       nbytes;
    logic [1:0]       gap;
    logic             exp_done;
    logic             exp_err;
    logic [1:0]       exp_nw;
    logic [31:0]      w0;
    logic [31:0]      w1;
  } vec_t;

  vec_t vecs[5];
  int   n_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Capture every memory write; the write cycle must never accept a byte.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(32'(imem_addr));
      wr_data_q.push_back(imem_wdata);
      chk("ready_during_we", 32'(in_ready), 32'd0);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("ready_in_reset", 32'(in_ready), 32'd0);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clock);
  endtask

  // Present one byte until accepted (bounded), then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      errors++;
      checks++;
      $display("FAIL byte_accept_timeout: got in_ready=0 for 200 cycles expected accept of %h", b);
    end else begin
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
    repeat (gap) @(negedge clock);
  endtask

  task automatic check_final(input string tag, input logic e_done, input logic e_err);
    repeat (4) @(negedge clock);
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".err"}, 32'(err), 32'(e_err));
    chk({tag, ".core_reset"}, 32'(core_reset), 32'(!e_done));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".nwrites"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      chk({tag, ".addr"}, wr_addr_q[i], exp_addr_q[i]);
      chk({tag, ".data"}, wr_data_q[i], exp_data_q[i]);
    end
  endtask

  logic [7:0]  s[$];
  int          cnt;
  logic [31:0] w;
  logic [7:0]  x;
  logic        good;
  logic        e_done;
  logic        e_err;

  initial begin
    // Directed table: basic, gapped, overlong, zero, bad checksum.
    vecs[0] = '{bytes: {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0, 8'h00},
                nbytes: 4'd10 + 4'(CSUM_EN), gap: 2'd0, exp_done: 1'b1, exp_err: 1'b0,
                exp_nw: 2'd2, w0: 32'h0000_0013, w1: 32'h0050_00B3};
    vecs[1] = vecs[0];
    vecs[1].gap = 2'd3;
    vecs[2] = '{bytes: {8'h41, 8'h00, 80'h0}, nbytes: 4'd2, gap: 2'd0, exp_done: 1'b0,
                exp_err: 1'b1, exp_nw: 2'd0, w0: 32'h0, w1: 32'h0};
    vecs[3] = '{bytes: {96'h0}, nbytes: 4'd2 + 4'(CSUM_EN), gap: 2'd1, exp_done: 1'b1,
                exp_err: 1'b0, exp_nw: 2'd0, w0: 32'h0, w1: 32'h0};
    n_vec = 4;
`ifdef LOADER_CHECKSUM_EN
    vecs[4] = vecs[0];
    vecs[4].bytes[10] = 8'h00;
    vecs[4].exp_done  = 1'b0;
    vecs[4].exp_err   = 1'b1;
    n_vec = 5;
`endif

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst.imem_we", 32'(imem_we), 32'd0);
    chk("rst.imem_addr", 32'(imem_addr), 32'd0);
    chk("rst.imem_wdata", imem_wdata, 32'd0);
    chk("rst.core_reset", 32'(core_reset), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.in_ready_after", 32'(in_ready), 32'd1);

    for (int v = 0; v < n_vec; v++) begin
      do_reset();
      for (int i = 0; i < int'(vecs[v].nbytes); i++) send_byte(vecs[v].bytes[i], int'(vecs[v].gap));
      exp_addr_q.delete();
      exp_data_q.delete();
      if (vecs[v].exp_nw >= 2'd1) begin exp_addr_q.push_back(32'd0); exp_data_q.push_back(vecs[v].w0); end
      if (vecs[v].exp_nw >= 2'd2) begin exp_addr_q.push_back(32'd1); exp_data_q.push_back(vecs[v].w1); end
      check_final($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
    end

    // Reset in the middle of a load, then a clean reload.
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(vecs[0].bytes[i], 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst.imem_we", 32'(imem_we), 32'd0);
    chk("midrst.imem_addr", 32'(imem_addr), 32'd0);
    chk("midrst.imem_wdata", imem_wdata, 32'd0);
    chk("midrst.core_reset", 32'(core_reset), 32'd1);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.err", 32'(err), 32'd0);
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < int'(vecs[0].nbytes); i++) send_byte(vecs[0].bytes[i], 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_addr_q.push_back(32'd0); exp_data_q.push_back(32'h0000_0013);
    exp_addr_q.push_back(32'd1); exp_data_q.push_back(32'h0050_00B3);
    check_final("midrst.reload", 1'b1, 1'b0);

    // Randomized images against the word-level model.
    for (int r = 0; r < 30; r++) begin
      s.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
      if (r == 0)                        cnt = DEPTH;
      else if ($urandom_range(0, 4) == 0) cnt = $urandom_range(DEPTH + 1, DEPTH + 700);
      else                               cnt = $urandom_range(0, 9);
      s.push_back(cnt[7:0]);
      s.push_back(cnt[15:8]);
      if (cnt > DEPTH) begin
        e_done = 1'b0;
        e_err  = 1'b1;
      end else begin
        x = 8'h00;
        for (int k = 0; k < cnt; k++) begin
          w = $urandom;
          for (int j = 0; j < 4; j++) s.push_back(w[8*j +: 8]);
          x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
          exp_addr_q.push_back(32'(k));
          exp_data_q.push_back(w);
        end
        good = 1'b1;
        if (CSUM_EN) begin
          good = ($urandom_range(0, 3) != 0);
          s.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
        end
        e_done = good;
        e_err  = !good;
      end
      do_reset();
      for (int i = 0; i < s.size(); i++) send_byte(s[i], $urandom_range(0, 2));
      check_final($sformatf("rand%0d", r), e_done, e_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
